// File: rtl/fifo_rd_pkg.sv
// Shared defaults and types for the FIFO read-side adapter.
package fifo_rd_pkg;
  localparam int DATA_W_DEF    = 8;
  localparam int BUF_DEPTH_DEF = 2;
  localparam int CNT_W         = 16;

  typedef logic [DATA_W_DEF-1:0] fifo_word_t;
endpackage

// File: rtl/fifo_rd_buf.sv
// Circular prefetch ring: push/pop in the same cycle keeps the count and advances both pointers.
module fifo_rd_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  localparam int PTR_W    = $clog2(BUF_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [PTR_W:0]    count
);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_read_adapter.sv
// Turns the 1-cycle-latency FIFO read port into a valid/ready stream via a small prefetch ring.
// Optional accepted-beat counter (rd_count) is built when FIFO_RD_CNT_EN is defined.
module fifo_read_adapter
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rn,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              idle
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_W-1:0]  rd_count
`endif
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam logic [PTR_W+1:0] DEPTH_L = (PTR_W+2)'(BUF_DEPTH);

  logic              inflight;
  logic [PTR_W:0]    buf_count;
  logic [PTR_W+1:0]  credit_used;
  logic [DATA_W-1:0] head_data;
  logic              pop;

  assign pop         = m_valid & m_ready;
  assign credit_used = {1'b0, buf_count} + {{(PTR_W+1){1'b0}}, inflight};

  // A full ring may still issue a read when a beat leaves this same cycle.
  assign fifo_rn = ~reset & enable & ~fifo_empty &
                   ((credit_used < DEPTH_L) | ((credit_used == DEPTH_L) & pop));

  // Stage boundary: read issued -> FIFO data lands one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) inflight <= 1'b0;
    else       inflight <= fifo_rn;
  end

  fifo_rd_buf #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (fifo_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (buf_count)
  );

  assign m_valid = (buf_count != '0);
  assign m_data  = m_valid ? head_data : '0;
  assign idle    = (buf_count == '0) & ~inflight & fifo_empty;

`ifdef FIFO_RD_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    rd_count <= '0;
    else if (pop) rd_count <= rd_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_read_adapter.sv
// Bench for fifo_read_adapter driving an 8-deep synchronous FIFO model with an in-order scoreboard.
module tb_fifo_read_adapter;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_empty;
  logic          fifo_rn;
  logic          m_valid;
  logic          idle;
  logic [DW-1:0] fifo_data;
  logic [DW-1:0] m_data;
`ifdef FIFO_RD_CNT_EN
  logic [15:0]   rd_count;
`endif

  fifo_read_adapter #(.DATA_W(DW), .BUF_DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rn    (fifo_rn),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .idle       (idle)
`ifdef FIFO_RD_CNT_EN
    ,
    .rd_count   (rd_count)
`endif
  );

  always #5 clk = ~clk;

  // 8-deep synchronous FIFO with registered data_out
  logic [DW-1:0] fmem [8];
  logic [2:0]    fwp, frp;
  logic [3:0]    fcnt;
  logic          wn = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          wr_ok, rd_ok;

  assign fifo_empty = (fcnt == 4'd0);
  assign wr_ok = wn && (fcnt != 4'd8);
  assign rd_ok = fifo_rn && (fcnt != 4'd0);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fwp <= 3'd0; frp <= 3'd0; fcnt <= 4'd0; fifo_data <= '0;
    end else begin
      if (wr_ok) begin fmem[fwp] <= wdata; fwp <= fwp + 3'd1; end
      if (rd_ok) begin fifo_data <= fmem[frp]; frp <= frp + 3'd1; end
      if (wr_ok && !rd_ok) fcnt <= fcnt + 4'd1;
      else if (!wr_ok && rd_ok) fcnt <= fcnt - 4'd1;
    end
  end

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q [$];

  int cyc = 0;
  int rn_cnt, beat_cnt, first_rn, first_vld, first_beat, last_beat;
  logic pv = 1'b0, pr = 1'b0;
  logic [DW-1:0] pd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: scoreboard, stall stability, no read while empty
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (reset) begin
      pv = 1'b0;
    end else begin
      if (fifo_rn) begin
        rn_cnt++;
        if (first_rn < 0) first_rn = cyc;
        total++;
        if (fifo_empty) begin
          bad++;
          $display("FAIL rn_while_empty cyc=%0d fifo_rn=%b required 0", cyc, fifo_rn);
        end
      end
      if (m_valid && first_vld < 0) first_vld = cyc;
      if (pv && !pr) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== pd) begin
          bad++;
          $display("FAIL stall_hold cyc=%0d got v=%b d=%h required v=1 d=%h", cyc, m_valid, m_data, pd);
        end
      end
      if (m_valid && m_ready) begin
        beat_cnt++;
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_beat cyc=%0d got %h required no beat", cyc, m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            bad++;
            $display("FAIL beat_data cyc=%0d got %h required %h", cyc, m_data, e);
          end
        end
      end
      pv = m_valid; pr = m_ready; pd = m_data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_stats();
    rn_cnt = 0; beat_cnt = 0; first_rn = -1; first_vld = -1; first_beat = -1; last_beat = -1;
  endtask

  task automatic preload(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      tick();
      wn = 1'b1; wdata = DW'(base + i);
      exp_q.push_back(DW'(base + i));
    end
    tick();
    wn = 1'b0;
  endtask

  task automatic wait_drain(input int limit, input string name);
    for (int k = 0; k < limit && exp_q.size() != 0; k++) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout left=%0d required 0", name, exp_q.size());
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #20;
    total++; if (fifo_rn !== 1'b0) begin bad++; $display("FAIL rst_rn got %b required 0", fifo_rn); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b required 0", m_valid); end
    total++; if (m_data !== '0) begin bad++; $display("FAIL rst_data got %h required 00", m_data); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle got %b required 1", idle); end
`ifdef FIFO_RD_CNT_EN
    total++; if (rd_count !== 16'd0) begin bad++; $display("FAIL rst_cnt got %0d required 0", rd_count); end
`endif
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    clear_stats();
    enable = 1'b0; m_ready = 1'b1;
    preload(8, 1);
    enable = 1'b1;
    wait_drain(40, "stream");
    total++; if (first_vld - first_rn !== 2) begin bad++; $display("FAIL stream_latency got %0d required 2", first_vld - first_rn); end
    total++; if (last_beat - first_beat !== 7) begin bad++; $display("FAIL stream_consecutive got %0d required 7", last_beat - first_beat); end
    total++; if (beat_cnt !== 8) begin bad++; $display("FAIL stream_beats got %0d required 8", beat_cnt); end
    total++; if (rn_cnt !== 8) begin bad++; $display("FAIL stream_rn got %0d required 8", rn_cnt); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL stream_idle got %b required 1", idle); end
    enable = 1'b0;
  endtask

  task automatic test_backpressure();
    clear_stats();
    enable = 1'b0; m_ready = 1'b0;
    preload(8, 1);
    enable = 1'b1;
    repeat (10) tick();
    total++; if (rn_cnt !== 2) begin bad++; $display("FAIL bp_rn_pulses got %0d required 2", rn_cnt); end
    total++; if (m_valid !== 1'b1 || m_data !== 8'd1) begin bad++; $display("FAIL bp_head got v=%b d=%h required v=1 d=01", m_valid, m_data); end
    total++; if (fcnt !== 4'd6) begin bad++; $display("FAIL bp_fifo_left got %0d required 6", fcnt); end
    m_ready = 1'b1;
    wait_drain(40, "bp");
    total++; if (beat_cnt !== 8) begin bad++; $display("FAIL bp_beats got %0d required 8", beat_cnt); end
    enable = 1'b0;
  endtask

  task automatic test_random();
    int i = 0;
    clear_stats();
    enable = 1'b1;
    for (int k = 0; k < 3000 && (i < 200 || exp_q.size() != 0); k++) begin
      tick();
      m_ready = 1'($urandom_range(0, 1));
      if (i < 200 && fcnt < 4'd8) begin
        wn = 1'b1; wdata = DW'(i); exp_q.push_back(DW'(i)); i++;
      end else begin
        wn = 1'b0;
      end
    end
    wn = 1'b0; m_ready = 1'b1;
    wait_drain(40, "random");
    total++; if (beat_cnt !== 200) begin bad++; $display("FAIL random_beats got %0d required 200", beat_cnt); end
    enable = 1'b0;
  endtask

  task automatic test_enable_drop();
    int b0;
    clear_stats();
    enable = 1'b0; m_ready = 1'b1;
    preload(8, 8'h40);
    enable = 1'b1;
    for (int k = 0; k < 30 && beat_cnt < 3; k++) tick();
    enable = 1'b0;
    b0 = beat_cnt;
    repeat (6) tick();
    total++; if (beat_cnt - b0 > 2) begin bad++; $display("FAIL drop_extra_beats got %0d required <=2", beat_cnt - b0); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL drop_valid got %b required 0", m_valid); end
    total++; if (int'(fcnt) !== 8 - beat_cnt || fcnt == 4'd0) begin bad++; $display("FAIL drop_fifo_left got %0d required %0d (nonzero)", fcnt, 8 - beat_cnt); end
    enable = 1'b1;
    wait_drain(40, "drop");
    total++; if (beat_cnt !== 8) begin bad++; $display("FAIL drop_beats got %0d required 8", beat_cnt); end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    clear_stats();
    enable = 1'b1; m_ready = 1'b0;
    preload(4, 8'h80);
    repeat (4) tick();
    total++; if (m_valid !== 1'b1 || m_data !== 8'h80) begin bad++; $display("FAIL mid_pre got v=%b d=%h required v=1 d=80", m_valid, m_data); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got %b required 0", m_valid); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL mid_idle got %b required 1", idle); end
    total++; if (fifo_rn !== 1'b0) begin bad++; $display("FAIL mid_rn got %b required 0", fifo_rn); end
`ifdef FIFO_RD_CNT_EN
    total++; if (rd_count !== 16'd0) begin bad++; $display("FAIL mid_cnt got %0d required 0", rd_count); end
`endif
    exp_q.delete();
    tick();
    reset = 1'b0;
    clear_stats();
    m_ready = 1'b1;
    preload(2, 8'hA5);
    wait_drain(40, "mid_recover");
    total++; if (beat_cnt !== 2) begin bad++; $display("FAIL mid_recover_beats got %0d required 2", beat_cnt); end
    enable = 1'b0;
  endtask

`ifdef FIFO_RD_CNT_EN
  task automatic test_counter();
    int i = 0;
    tick(); reset = 1'b1; tick(); reset = 1'b0;
    clear_stats();
    enable = 1'b1; m_ready = 1'b1;
    for (int k = 0; k < 75000 && (i < 70000 || exp_q.size() != 0); k++) begin
      tick();
      if (i < 70000 && fcnt < 4'd8) begin
        wn = 1'b1; wdata = DW'(i); exp_q.push_back(DW'(i)); i++;
      end else begin
        wn = 1'b0;
      end
    end
    wn = 1'b0;
    wait_drain(40, "cnt");
    total++; if (beat_cnt !== 70000) begin bad++; $display("FAIL cnt_beats got %0d required 70000", beat_cnt); end
    total++; if (rd_count !== 16'd4464) begin bad++; $display("FAIL cnt_wrap got %0d required 4464", rd_count); end
    enable = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_enable_drop();
    test_reset_mid();
`ifdef FIFO_RD_CNT_EN
    test_counter();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
